// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Oversampled UART receiver with a 2-of-3 majority vote,
//               false-start rejection, error flags and a valid/ready buffer.
//               Define RX_PARITY_EN to add one parity bit after the data bits.
// Revision    : 1.0  initial parametrised release
// ============================================================================
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 baudClk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 parityOdd,
  output logic [DATA_BITS-1:0] rxData,
  output logic                 rxValid,
  input  logic                 rxReady,
  output logic                 rxDone,
  output logic                 frameErr,
  output logic                 parityErr,
  output logic                 breakDet,
  output logic                 overrun
);

  localparam int c_CNT_W = $clog2(OVERSAMPLE);
  localparam int c_IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [c_CNT_W-1:0] c_HALF      = c_CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(OVERSAMPLE - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_BIT  = c_IDX_W'(DATA_BITS - 1);
  localparam logic               c_LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                 r_state;
  logic                   r_rxMeta;
  logic                   r_rxS;
  logic [2:0]             r_hist;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_IDX_W-1:0]     r_bitIdx;
  logic                   r_stopIdx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_stopLow;
  logic                   r_breakHold;

  logic w_majority;
  logic w_cntHit;
  logic w_parityErr;
  logic w_break;

  assign w_majority = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
  assign w_cntHit   = (r_cnt == c_FULL);

`ifdef RX_PARITY_EN
  logic r_parityBit;
  assign w_parityErr = ((^r_shift) ^ r_parityBit) != parityOdd;
  assign w_break     = (r_shift == '0) && !r_parityBit && r_stopLow;
`else
  logic w_unusedParityOdd;
  assign w_unusedParityOdd = parityOdd;
  assign w_parityErr       = 1'b0;
  assign w_break           = (r_shift == '0) && r_stopLow;
`endif

  always_ff @(posedge baudClk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_rxMeta    <= 1'b1;
      r_rxS       <= 1'b1;
      r_hist      <= 3'b111;
      r_cnt       <= '0;
      r_bitIdx    <= '0;
      r_stopIdx   <= 1'b0;
      r_shift     <= '0;
      r_stopLow   <= 1'b0;
      r_breakHold <= 1'b0;
`ifdef RX_PARITY_EN
      r_parityBit <= 1'b0;
`endif
      rxData      <= '0;
      rxValid     <= 1'b0;
      rxDone      <= 1'b0;
      frameErr    <= 1'b0;
      parityErr   <= 1'b0;
      breakDet    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      r_rxMeta <= rx;
      r_rxS    <= r_rxMeta;
      r_hist   <= {r_hist[1:0], r_rxS};
      rxDone   <= 1'b0;
      if (rxValid && rxReady) rxValid <= 1'b0;

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          // After a break the line must go high before a new start counts.
          if (r_rxS)             r_breakHold <= 1'b0;
          else if (!r_breakHold) r_state     <= START;
        end
        START: begin
          if (r_cnt == c_HALF) begin
            r_cnt     <= '0;
            r_bitIdx  <= '0;
            r_stopIdx <= 1'b0;
            r_stopLow <= 1'b0;
            r_state   <= w_majority ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_cntHit) begin
            r_cnt             <= '0;
            r_shift[r_bitIdx] <= w_majority;
            if (r_bitIdx == c_LAST_BIT) begin
`ifdef RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bitIdx <= r_bitIdx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef RX_PARITY_EN
        PARITY: begin
          if (w_cntHit) begin
            r_cnt       <= '0;
            r_parityBit <= w_majority;
            r_state     <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_cntHit) begin
            r_cnt <= '0;
            if (!w_majority) r_stopLow <= 1'b1;
            if (r_stopIdx == c_LAST_STOP) r_state   <= DONE;
            else                          r_stopIdx <= r_stopIdx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          rxDone      <= 1'b1;
          r_breakHold <= w_break;
          r_state     <= IDLE;
          // A reload on the consume tick overrides the clear above.
          if (!rxValid || rxReady) begin
            rxData    <= r_shift;
            frameErr  <= r_stopLow;
            parityErr <= w_parityErr;
            breakDet  <= w_break;
            rxValid   <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Directed and random frame bench for uart_rx_param (8 data,
//               x16 oversample, 1 stop); parity steps appear with RX_PARITY_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_param;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int SB = 1;

  logic          baudClk = 1'b0;
  logic          reset;
  logic          rx;
  logic          parityOdd;
  logic [DB-1:0] rxData;
  logic          rxValid;
  logic          rxReady;
  logic          rxDone;
  logic          frameErr;
  logic          parityErr;
  logic          breakDet;
  logic          overrun;

  uart_rx_param #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(SB)) dut (
    .baudClk  (baudClk),
    .reset    (reset),
    .rx       (rx),
    .parityOdd(parityOdd),
    .rxData   (rxData),
    .rxValid  (rxValid),
    .rxReady  (rxReady),
    .rxDone   (rxDone),
    .frameErr (frameErr),
    .parityErr(parityErr),
    .breakDet (breakDet),
    .overrun  (overrun)
  );

  always #5 baudClk = ~baudClk;

  int nAssert = 0;
  int nFail   = 0;

  int            cyc         = 0;
  int            doneCount   = 0;
  int            doneCyc     = 0;
  int            validCycles = 0;
  int            riseCyc     = 0;
  int            stopStart   = 0;
  logic          prevValid   = 1'b0;
  logic [DB-1:0] capData     = '0;
  logic          capFe       = 1'b0;
  logic          capPe       = 1'b0;
  logic          capBrk      = 1'b0;

  always @(posedge baudClk) cyc <= cyc + 1;

  // Observer: counts frame-end pulses and snapshots each newly presented word.
  always @(negedge baudClk) begin
    prevValid <= rxValid;
    if (rxDone) begin
      doneCount <= doneCount + 1;
      doneCyc   <= cyc;
    end
    if (rxValid) validCycles <= validCycles + 1;
    if (rxValid && !prevValid) begin
      capData <= rxData;
      capFe   <= frameErr;
      capPe   <= parityErr;
      capBrk  <= breakDet;
      riseCyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge baudClk);
  endtask

  task automatic sendBit(input logic b);
    rx = b;
    repeat (OS) @(negedge baudClk);
  endtask

  task automatic sendFrame(input logic [DB-1:0] d, input logic stopV, input logic parBit);
    sendBit(1'b0);
    for (int i = 0; i < DB; i++) sendBit(d[i]);
`ifdef RX_PARITY_EN
    sendBit(parBit);
`else
    if (parBit === 1'bx) rx = 1'b0;
`endif
    for (int s = 0; s < SB; s++) begin
      if (s == 0) stopStart = cyc;
      sendBit(stopV);
    end
  endtask

  // Reference flags from the frame contents as transmitted.
  function automatic logic modelParityErr(input logic [DB-1:0] d, input logic parBit, input logic odd);
`ifdef RX_PARITY_EN
    return ((($countones(d) + int'(parBit)) % 2) != int'(odd));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic modelBreak(input logic [DB-1:0] d, input logic stopV, input logic parBit);
`ifdef RX_PARITY_EN
    return (d == '0) && !stopV && !parBit;
`else
    return (d == '0) && !stopV && (parBit | !parBit);
`endif
  endfunction

  function automatic logic goodParity(input logic [DB-1:0] d, input logic odd);
    return logic'(($countones(d) % 2) != int'(odd));
  endfunction

  // Send one frame with rxReady=1 and check the delivered word and its timing.
  task automatic deliver(input string tag, input logic [DB-1:0] d, input logic stopV, input logic parBit);
    int dBefore;
    int vBefore;
    int lat;
    dBefore = doneCount;
    vBefore = validCycles;
    sendFrame(d, stopV, parBit);
    idle(4);
    lat = doneCyc - stopStart;
    check({tag, ".doneCount"}, 32'(doneCount - dBefore), 32'd1);
    check({tag, ".data"},      32'(capData), 32'(d));
    check({tag, ".frameErr"},  32'(capFe),   32'(!stopV));
    check({tag, ".parityErr"}, 32'(capPe),   32'(modelParityErr(d, parBit, parityOdd)));
    check({tag, ".breakDet"},  32'(capBrk),  32'(modelBreak(d, stopV, parBit)));
    check({tag, ".validLen"},  32'(validCycles - vBefore), 32'd1);
    check({tag, ".riseWithDone"}, 32'(riseCyc == doneCyc), 32'd1);
    check({tag, ".latencyInStop"}, 32'(lat >= OS / 2 && lat <= OS), 32'd1);
  endtask

  initial begin
    logic [DB-1:0] d;
    logic          p;
    int            dBefore;

    reset     = 1'b0;
    rx        = 1'b1;
    rxReady   = 1'b1;
    parityOdd = 1'b0;
    idle(5);
    check("rst.rxData",    32'(rxData),    32'd0);
    check("rst.rxValid",   32'(rxValid),   32'd0);
    check("rst.rxDone",    32'(rxDone),    32'd0);
    check("rst.frameErr",  32'(frameErr),  32'd0);
    check("rst.parityErr", 32'(parityErr), 32'd0);
    check("rst.breakDet",  32'(breakDet),  32'd0);
    check("rst.overrun",   32'(overrun),   32'd0);
    reset = 1'b1;
    idle(2 * OS);

    deliver("x55", 8'h55, 1'b1, goodParity(8'h55, 1'b0));

`ifdef RX_PARITY_EN
    parityOdd = 1'b0;
    deliver("parBad",  8'hA3, 1'b1, 1'b1);
    deliver("parGood", 8'hA3, 1'b1, 1'b0);
    parityOdd = 1'b1;
    deliver("parOdd",  8'hA3, 1'b1, 1'b1);
    parityOdd = 1'b0;
`endif

    for (int k = 0; k < 6; k++) begin
      d         = DB'($urandom);
      parityOdd = 1'($urandom);
      p         = ($urandom_range(0, 3) == 0) ? !goodParity(d, parityOdd) : goodParity(d, parityOdd);
      deliver($sformatf("rand%0d", k), d, 1'b1, p);
      idle($urandom_range(0, OS));
    end
    parityOdd = 1'b0;

    // Short low pulse must be rejected as a false start.
    dBefore = doneCount;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(3 * OS);
    check("glitch.noDone",  32'(doneCount - dBefore), 32'd0);
    check("glitch.rxValid", 32'(rxValid), 32'd0);

    // Break frame, then line held low for 40 bit times.
    deliver("break", '0, 1'b0, 1'b0);
    dBefore = doneCount;
    idle(40 * OS);
    check("break.heldLow", 32'(doneCount - dBefore), 32'd0);
    rx = 1'b1;
    idle(2 * OS);
    check("break.released", 32'(doneCount - dBefore), 32'd0);
    deliver("afterBreak", 8'h96, 1'b1, goodParity(8'h96, 1'b0));

    // Overrun: two frames back to back with no consumer.
    rxReady = 1'b0;
    dBefore = doneCount;
    sendFrame(8'h11, 1'b1, goodParity(8'h11, 1'b0));
    sendFrame(8'h22, 1'b1, goodParity(8'h22, 1'b0));
    idle(4);
    check("ovr.doneCount", 32'(doneCount - dBefore), 32'd2);
    check("ovr.rxData",    32'(rxData),   32'h11);
    check("ovr.rxValid",   32'(rxValid),  32'd1);
    check("ovr.overrun",   32'(overrun),  32'd1);
    check("ovr.frameErr",  32'(frameErr), 32'd0);
    rxReady = 1'b1;
    idle(1);
    check("ovr.validDrop",   32'(rxValid), 32'd0);
    check("ovr.overrunKept", 32'(overrun), 32'd1);
    idle(OS);

    // Reset in the middle of data bit 3 of 0xF0.
    d = 8'hF0;
    sendBit(1'b0);
    for (int i = 0; i < 3; i++) sendBit(d[i]);
    rx = d[3];
    idle(OS / 2);
    reset = 1'b0;
    rx    = 1'b1;
    idle(3);
    check("midRst.rxValid", 32'(rxValid), 32'd0);
    check("midRst.overrun", 32'(overrun), 32'd0);
    check("midRst.rxData",  32'(rxData),  32'd0);
    reset   = 1'b1;
    dBefore = doneCount;
    idle(3 * OS);
    check("midRst.noDone", 32'(doneCount - dBefore), 32'd0);
    deliver("x3C", 8'h3C, 1'b1, goodParity(8'h3C, 1'b0));
    check("x3C.overrun", 32'(overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
`default_nettype wire
